ysyx_25040111_mdu_seq: RTL

//  Iterative RV32M sequencer for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (funct7=0000001).

---
 rtl/ysyx_25040111_mdu_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ysyx_25040111_mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: one shift-add or
// restoring-divide step per cycle on a shared 2*XLEN datapath.
module ysyx_25040111_mdu_seq #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fun3,
  input  logic [XLEN-1:0]  src1,
  input  logic [XLEN-1:0]  src2,
  input  logic [TAG_W-1:0] in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_rd
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q;
  logic [2:0]         op_q;
  logic [CW-1:0]      cnt_q;
  logic [2*XLEN-1:0]  acc_q;
  logic [XLEN-1:0]    dvs_q;
  logic               negq_q;
  logic               negr_q;
  logic [XLEN-1:0]    res_q;
  logic [TAG_W-1:0]   rd_q;
  logic               vld_q;

  logic              is_div, sg1, sg2, s1, s2;
  logic              div0, ovf;
  logic [XLEN-1:0]   a_mag, b_mag, spec_res;

  assign is_div = fun3[2];
  assign sg1 = (fun3 == 3'b001) | (fun3 == 3'b010)
             | (fun3 == 3'b100) | (fun3 == 3'b110);
  assign sg2 = (fun3 == 3'b001) | (fun3 == 3'b100)
             | (fun3 == 3'b110);
  assign s1 = sg1 & src1[XLEN-1];
  assign s2 = sg2 & src2[XLEN-1];
  assign a_mag = s1 ? (~src1 + 1'b1) : src1;
  assign b_mag = s2 ? (~src2 + 1'b1) : src2;

  assign div0 = is_div & (src2 == '0);
  assign ovf  = is_div & ~fun3[0] & (&src2)
              & (src1 == {1'b1, {(XLEN-1){1'b0}}});
  // Overflow quotient equals the dividend itself (most negative value)
  assign spec_res = div0 ? (fun3[1] ? src1 : '1)
                         : (fun3[1] ? '0 : src1);

  logic [XLEN:0]      mul_sum, trem, tsub;
  logic               ge;
  logic [XLEN-1:0]    nrem;
  logic [2*XLEN-1:0]  mul_nxt, div_nxt, stp_nxt, prod;
  logic [XLEN-1:0]    quo, rmd, fix_res;

  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + {1'b0, (acc_q[0] ? dvs_q : '0)};
  assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

  assign trem = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign ge   = trem >= {1'b0, dvs_q};
  assign tsub = trem - {1'b0, dvs_q};
  assign nrem = ge ? tsub[XLEN-1:0] : trem[XLEN-1:0];
  assign div_nxt = {nrem, acc_q[XLEN-2:0], ge};

  assign stp_nxt = op_q[2] ? div_nxt : mul_nxt;

  // Sign fix-up on the last step's value so DONE shows the final answer
  assign prod = negq_q ? (~stp_nxt + 1'b1) : stp_nxt;
  assign quo  = negq_q ? (~stp_nxt[XLEN-1:0] + 1'b1)
                       : stp_nxt[XLEN-1:0];
  assign rmd  = negr_q ? (~stp_nxt[2*XLEN-1:XLEN] + 1'b1)
                       : stp_nxt[2*XLEN-1:XLEN];
  assign fix_res = op_q[2] ? (op_q[1] ? rmd : quo)
                 : (op_q == 3'b000) ? prod[XLEN-1:0]
                 : prod[2*XLEN-1:XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
      rd_q    <= '0;
      vld_q   <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q   <= fun3;
            rd_q   <= in_rd;
            negq_q <= s1 ^ s2;
            negr_q <= s1;
            if (div0 | ovf) begin
              res_q   <= spec_res;
              vld_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q   <= CW'(XLEN);
              acc_q   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
              dvs_q   <= is_div ? b_mag : a_mag;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= stp_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            res_q   <= fix_res;
            vld_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            vld_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = vld_q;
  assign result    = res_q;
  assign out_rd    = rd_q;

endmodule
